// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcodes, instruction-type codes and instruction field positions.
package mips32_pkg;

  localparam logic [5:0] ADD   = 6'b000000;
  localparam logic [5:0] SUB   = 6'b000001;
  localparam logic [5:0] AND   = 6'b000010;
  localparam logic [5:0] OR    = 6'b000011;
  localparam logic [5:0] SLT   = 6'b000100;
  localparam logic [5:0] MUL   = 6'b000101;
  localparam logic [5:0] LW    = 6'b001000;
  localparam logic [5:0] SW    = 6'b001001;
  localparam logic [5:0] ADDI  = 6'b001010;
  localparam logic [5:0] SUBI  = 6'b001011;
  localparam logic [5:0] SLTI  = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101;
  localparam logic [5:0] BEQZ  = 6'b001110;
  localparam logic [5:0] HLT   = 6'b111111;

  typedef enum logic [2:0] {
    RR_ALU = 3'd0,
    RM_ALU = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd5
  } instr_type_e;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RS_MSB  = 25;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_MSB  = 20;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_MSB  = 15;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush; head is presented straight from the storage registers.
module sync_fifo #(
  parameter int unsigned  Width = 64,
  parameter int unsigned  Depth = 4,
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CntW-1:0]  count,
  output logic [Width-1:0] head,
  output logic             not_empty
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // Accept a push into a full FIFO only when the head leaves in the same cycle.
    do_push  = push && ((count_q != CntW'(Depth)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: PC counter, one outstanding imem read, and a prefetch FIFO to ID.
module if_prefetch
  import mips32_pkg::*;
#(
  parameter int unsigned  DEPTH = 4,
  parameter int unsigned  AW    = 10,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk1,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_ir,
  output logic [31:0]   out_npc,
  output logic          halted,
  output logic [CW-1:0] occupancy
);

  logic [31:0] pc_q, pc_d, inflight_npc_q, inflight_npc_d;
  logic        inflight_q, inflight_d, stop_q, stop_d;
  logic [CW:0] credit_used;
  logic        issue, push, pop, is_hlt;
  logic [63:0] fifo_head;

  always_comb begin
    credit_used    = {1'b0, occupancy} + {{CW{1'b0}}, inflight_q};
    issue          = !stop_q && !redirect && (credit_used < (CW + 1)'(DEPTH));
    is_hlt         = (imem_rdata[OP_MSB:OP_LSB] == HLT);
    // stop_q already set means this response was issued alongside the HLT response: drop it.
    push           = inflight_q && !stop_q && !redirect;
    pop            = out_valid && out_ready;
    pc_d           = pc_q;
    inflight_npc_d = inflight_npc_q;
    inflight_d     = issue;
    stop_d         = stop_q;
    if (redirect) begin
      pc_d   = redirect_pc;
      stop_d = 1'b0;
    end else begin
      if (issue) begin
        pc_d           = pc_q + 32'd1;
        inflight_npc_d = pc_q + 32'd1;
      end
      if (push && is_hlt) begin
        stop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      pc_q           <= '0;
      inflight_npc_q <= '0;
      inflight_q     <= 1'b0;
      stop_q         <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      inflight_npc_q <= inflight_npc_d;
      inflight_q     <= inflight_d;
      stop_q         <= stop_d;
    end
  end

  sync_fifo #(
    .Width (64),
    .Depth (DEPTH)
  ) u_fifo (
    .clk1      (clk1),
    .rst       (rst),
    .push      (push),
    .push_data ({imem_rdata, inflight_npc_q}),
    .pop       (pop),
    .flush     (redirect),
    .count     (occupancy),
    .head      (fifo_head),
    .not_empty (out_valid)
  );

  // Gate with rst so the request drops the moment reset is asserted.
  assign imem_req  = issue && !rst;
  assign imem_addr = pc_q[AW-1:0];
  assign out_ir    = fifo_head[63:32];
  assign out_npc   = fifo_head[31:0];
  assign halted    = stop_q;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed table and sequences plus random traffic against a queue model.
module tb_if_prefetch;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned AW     = 10;
  localparam int unsigned CW     = $clog2(DEPTH + 1);
  localparam logic [5:0]  OP_HLT = 6'h3F;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_ir, out_npc;
  logic          halted;
  logic [CW-1:0] occupancy;

  if_prefetch #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk1        (clk1),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ir      (out_ir),
    .out_npc     (out_npc),
    .halted      (halted),
    .occupancy   (occupancy)
  );

  always #5 clk1 = ~clk1;

  logic [31:0] mem [1024];
  always @(posedge clk1) if (imem_req) imem_rdata <= mem[imem_addr];

  // Reference model: output queue of {ir, npc}, PC, one pending read, stop flag.
  logic [63:0]   mq[$];
  logic [31:0]   m_pc, m_pend_npc;
  logic [AW-1:0] m_pend_addr;
  bit            m_stop, m_pend, m_pend_kill;
  int            vecs = 0;
  int            errs = 0;

  typedef struct {
    logic          rdy;
    logic          e_valid;
    logic [31:0]   e_ir;
    logic [31:0]   e_npc;
    logic [CW-1:0] e_occ;
    logic          e_req;
    logic [AW-1:0] e_addr;
  } vec_t;
  vec_t        tbl[10];
  logic [31:0] seen[$];

  function automatic bit model_req();
    return !m_stop && !redirect && ((mq.size() + int'(m_pend)) < DEPTH);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc        = '0;
    m_stop      = 0;
    m_pend      = 0;
    m_pend_kill = 0;
  endtask

  task automatic model_update();
    bit          issue;
    bit          hlt_pushed;
    logic [31:0] w;
    issue      = model_req();
    hlt_pushed = 0;
    if (out_ready && mq.size() != 0) void'(mq.pop_front());
    if (redirect) begin
      mq.delete();
      m_pc   = redirect_pc;
      m_stop = 0;
      m_pend = 0;
      return;
    end
    if (m_pend && !m_pend_kill) begin
      w = mem[m_pend_addr];
      mq.push_back({w, m_pend_npc});
      if (w[31:26] == OP_HLT) begin
        m_stop     = 1;
        hlt_pushed = 1;
      end
    end
    m_pend      = issue;
    m_pend_kill = hlt_pushed;
    if (issue) begin
      m_pend_addr = m_pc[AW-1:0];
      m_pend_npc  = m_pc + 32'd1;
      m_pc        = m_pc + 32'd1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit ereq;
    ereq = model_req();
    chk("out_valid", out_valid, mq.size() != 0);
    chk("occupancy", occupancy, mq.size());
    chk("halted", halted, m_stop);
    chk("imem_req", imem_req, ereq);
    if (ereq) chk("imem_addr", imem_addr, m_pc[AW-1:0]);
    if (mq.size() != 0) begin
      chk("out_ir", out_ir, mq[0][63:32]);
      chk("out_npc", out_npc, mq[0][31:0]);
    end
  endtask

  // Advance one clock, then apply inputs for the new cycle and check it.
  task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
    @(posedge clk1);
    model_update();
    @(negedge clk1);
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    #1;
    compare_all();
  endtask

  task automatic do_reset(input logic rdy);
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = rdy;
    model_reset();
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    chk("rst_valid", out_valid, 0);
    chk("rst_ir", out_ir, 0);
    chk("rst_npc", out_npc, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    rst = 1'b0;
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 1024; i++) mem[i] = {6'h00, 16'(i), 10'h020};

    // Reset release with out_ready high: Mem[0..] stream out from cycle 2.
    for (int k = 0; k < 10; k++) begin
      tbl[k].rdy     = 1'b1;
      tbl[k].e_valid = (k >= 2);
      tbl[k].e_ir    = (k >= 2) ? mem[k-2] : 32'h0;
      tbl[k].e_npc   = (k >= 2) ? 32'(k - 1) : 32'h0;
      tbl[k].e_occ   = (k >= 2) ? CW'(1) : CW'(0);
      tbl[k].e_req   = 1'b1;
      tbl[k].e_addr  = AW'(k);
    end
    do_reset(1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step(1'b0, 32'h0, tbl[k].rdy);
      chk("tbl_valid", out_valid, tbl[k].e_valid);
      chk("tbl_occ", occupancy, tbl[k].e_occ);
      chk("tbl_req", imem_req, tbl[k].e_req);
      chk("tbl_addr", imem_addr, tbl[k].e_addr);
      if (tbl[k].e_valid) begin
        chk("tbl_ir", out_ir, tbl[k].e_ir);
        chk("tbl_npc", out_npc, tbl[k].e_npc);
      end
    end

    // Backpressure: occupancy saturates and requests stop, then drains in order.
    for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 1'b0);
    chk("bp_occ_full", occupancy, DEPTH);
    chk("bp_req_low", imem_req, 0);
    for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1);

    // Redirect to 0x20 while full, with a handshake in the redirect cycle.
    for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b0);
    chk("rd_pre_full", occupancy, DEPTH);
    step(1'b1, 32'h20, 1'b1);
    chk("rd_req_low", imem_req, 0);
    step(1'b0, 32'h0, 1'b1);
    chk("rd_t1_valid", out_valid, 0);
    chk("rd_t1_addr", imem_addr, 10'h20);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("rd_t3_valid", out_valid, 1);
    chk("rd_t3_ir", out_ir, mem[32]);
    chk("rd_t3_npc", out_npc, 32'h21);

    // HLT at Mem[3]: only Mem[0..3] come out, then redirect resumes.
    mem[3] = {OP_HLT, 26'h0};
    do_reset(1'b1);
    seen.delete();
    for (int k = 0; k < 12; k++) begin
      if (out_valid && out_ready) seen.push_back(out_ir);
      step(1'b0, 32'h0, 1'b1);
    end
    chk("hlt_count", seen.size(), 4);
    for (int i = 0; i < seen.size() && i < 4; i++) chk("hlt_seq", seen[i], mem[i]);
    chk("hlt_halted", halted, 1);
    chk("hlt_req_low", imem_req, 0);
    step(1'b1, 32'h10, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("hlt_clear", halted, 0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("hlt_resume_ir", out_ir, mem[16]);
    chk("hlt_resume_npc", out_npc, 32'h11);
    mem[3] = {6'h00, 16'(3), 10'h020};

    // Address wrap at the top of imem.
    step(1'b1, 32'h3FF, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("wrap_ir0", out_ir, mem[1023]);
    chk("wrap_npc0", out_npc, 32'h400);
    step(1'b0, 32'h0, 1'b1);
    chk("wrap_ir1", out_ir, mem[0]);
    chk("wrap_npc1", out_npc, 32'h401);

    // Asynchronous reset mid-stream with a read outstanding.
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_req", imem_req, 0);
    chk("arst_ir", out_ir, 0);
    chk("arst_npc", out_npc, 0);
    chk("arst_addr", imem_addr, 0);
    do_reset(1'b1);
    chk("arst_restart_addr", imem_addr, 0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("arst_restart_ir", out_ir, mem[0]);

    // Random traffic with sprinkled HLTs, redirects and backpressure.
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      if ($urandom_range(0, 31) == 0) w[31:26] = OP_HLT;
      else if (w[31:26] == OP_HLT) w[31:26] = 6'h00;
      mem[i] = w;
    end
    do_reset(1'b1);
    for (int k = 0; k < 3000; k++) begin
      logic        rd;
      logic [31:0] rpc;
      rd = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0:       rpc = 32'($urandom_range(0, 1023));
        1:       rpc = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: rpc = $urandom;
      endcase
      step(rd, rpc, ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Instruction-fetch front end for the MIPS32 pipeline. It sits directly upstream of the ID stage, replacing the bare PC/IF latch. It runs a PC counter, issues reads to synchronous instruction memory, and buffers returned words with their next-PC in a small FIFO. ID drains the FIFO over a valid/ready handshake. The block handles branch redirects from EX and stops fetching when it fetches HLT.

## Interface
Parameters:
- DEPTH, 4: prefetch FIFO entries (power of two, ≥2).
- AW, 10: instruction-memory word-address width (1024-word memory).

Ports:
- clk1, input, 1: the block's single clock; all state updates on the rising edge.
- rst, input, 1: reset; asynchronous, active-high.
- imem_req, output, 1: read request; rdata returns exactly one cycle later.
- imem_addr, output, AW: word address, equal to PC[AW-1:0].
- imem_rdata, input, 32: read data for the request issued in the previous cycle.
- redirect, input, 1: taken branch from EX; one-cycle pulse.
- redirect_pc, input, 32: branch target (EX ALUOut).
- out_valid, output, 1: FIFO head holds an instruction.
- out_ready, input, 1: ID accepts the head this cycle.
- out_ir, output, 32: head instruction word.
- out_npc, output, 32: head's PC+1.
- halted, output, 1: HLT has been fetched; fetching is stopped.
- occupancy, output, $clog2(DEPTH+1): FIFO entry count.

## Operation
- State:
  - PC (32-bit).
  - FIFO of {ir, npc}.
  - inflight flag plus inflight_npc, for the single outstanding read.
  - stop flag, which drives halted.
- Reset values:
  - PC=0, FIFO empty, inflight=0, stop=0.
  - Outputs: imem_req=0, imem_addr=0, out_valid=0, out_ir=0, out_npc=0, halted=0, occupancy=0.
- Issue rule: imem_req=1 when !stop && !redirect && (occupancy + inflight) < DEPTH.
  - The credit check is conservative: a same-cycle pop is not counted.
  - On issue, PC <= PC+1 and inflight_npc <= PC+1.
  - PC wraps modulo 2^32; imem_addr wraps modulo 2^AW.
- Response: in the cycle after an issue, {imem_rdata, inflight_npc} is pushed into the FIFO unless that response is killed.
  - Credit reservation guarantees the FIFO never overflows.
- HLT detection: when a pushed word has opcode [31:26]=6'b111111, stop <= 1 and the HLT itself is pushed.
  - A request issued in the same cycle as the HLT response is killed: its response is dropped.
  - No further requests are made while stop=1.
- Redirect (highest priority):
  - FIFO is flushed and any response due next cycle is killed.
  - PC <= redirect_pc and stop <= 0.
  - imem_req=0 in the redirect cycle.
  - If out_valid && out_ready in the same cycle, that handshake still completes (ID consumed the entry), then the flush applies.
- Pop: out_valid && out_ready removes the head.
  - A pop on an empty FIFO is a no-op.
  - Simultaneous push and pop leaves occupancy unchanged.
- out_ir and out_npc come straight from the FIFO head registers, with no combinational path from out_ready.

## Timing
- Cycle 0 is the first rising edge with rst low:
  - imem_req=1, addr 0 at cycle 0.
  - Data pushed at cycle 1.
  - out_valid=1 from cycle 2, out_ir=Mem[0], out_npc=1.
- Steady state with out_ready held high: one instruction per cycle.
- Redirect at cycle t:
  - out_valid=0 at t+1.
  - Request for the target at t+1.
  - Target visible on out_* at t+3.
- Fetch-to-output latency is 2 cycles.
- rst asserted mid-operation: all state returns to reset values immediately (asynchronously), including inflight and stop.

## Structure
- Shared package mips32_pkg holds:
  - the opcode constants (ADD…HLT, LW, SW, BEQZ, BNEQZ),
  - the instruction-type codes (RR_ALU…HALT),
  - the instruction field slice positions.
- This block imports HLT from that package.
- One sub-module, sync_fifo, which is reused later by the MEM-side store buffer:
  - parameterised on width and depth,
  - push/pop/flush, count, head outputs,
  - same clock/reset ports.
- Top level holds the PC, the issue/credit logic, the kill logic and the stop flag.

## Test plan
- Reset release, memory 0..7 = distinct ADDs, out_ready=1: out_ir = Mem[0..7] on consecutive cycles from cycle 2; out_npc = 1..8.
- out_ready=0 for 10 cycles: occupancy saturates at 4 and imem_req drops to 0. Then out_ready=1: entries drain in order with no loss or duplication.
- Redirect to 0x20 while FIFO is full (PC=6):
  - FIFO empties; the response due next cycle is dropped.
  - The next out_ir is Mem[0x20] with out_npc=0x21, 3 cycles after the redirect.
  - A handshake in the redirect cycle counts.
- HLT at Mem[3]:
  - halted=1 after the push; Mem[4] never appears on out_*.
  - out_ir sequence is Mem[0..3].
  - A later redirect to 0x10 clears halted and resumes fetch.
- Wrap: redirect to 32'h3FF (AW=10): fetch Mem[1023], then Mem[0]; out_npc = 0x400, 0x401.
- rst pulsed mid-stream with inflight=1: all outputs return to 0 at once; after release, fetch restarts at address 0.
